// File: rtl/score_history_unit_pkg.sv
// Shared definitions for the reaction-timer result path: timeout code, view
// encodings and BCD digit validation (also used by the millisecond counter).
package score_history_unit_pkg;

    localparam logic [15:0] TIMEOUT_CODE = 16'h9999;

    typedef enum logic [1:0] {
        VIEW_LAST = 2'd0,
        VIEW_BEST = 2'd1,
        VIEW_HIST = 2'd2
    } view_t;

    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    function automatic logic bcd_word_ok(input logic [15:0] word);
        return bcd_digit_ok(word[15:12]) && bcd_digit_ok(word[11:8]) &&
               bcd_digit_ok(word[7:4])   && bcd_digit_ok(word[3:0]);
    endfunction

endpackage

// File: rtl/score_history_unit_if.sv
// Control/data bundle between the game FSM, the score history unit and the
// segment controller. master drives updates and view buttons; slave is the unit.
interface score_history_unit_if #(
    parameter int DEPTH = 4
);
    localparam int IW = $clog2(DEPTH);

    logic          Update;
    logic          Timeout;
    logic [15:0]   ScoreIn;
    logic          ShowBest;
    logic          ShowPrev;
    logic [15:0]   ScoreOut;
    logic          BestValid;
    logic [IW-1:0] HistIdx;
    logic          BadBcd;

    modport master (
        output Update, Timeout, ScoreIn, ShowBest, ShowPrev,
        input  ScoreOut, BestValid, HistIdx, BadBcd
    );

    modport slave (
        input  Update, Timeout, ScoreIn, ShowBest, ShowPrev,
        output ScoreOut, BestValid, HistIdx, BadBcd
    );

endinterface

// File: rtl/score_history_unit_ring_buffer.sv
// Recent-score ring buffer: write pointer, saturating fill count and a
// read port indexed backwards from the newest entry.
module score_ring_buffer #(
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = IW + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   rd_data,
    output logic [CW-1:0] cnt
);

    logic [15:0]   hist [DEPTH];
    logic [IW-1:0] wp;
    logic [IW-1:0] rd_ptr;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    always_comb begin
        rd_ptr  = wp - 1'b1 - rd_idx;
        rd_data = hist[rd_ptr];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (wr_en) begin
            hist[wp] <= wr_data;
            wp       <= wp + 1'b1;
            if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/score_history_unit.sv
// Captures reaction-time scores, tracks the best valid one and selects the
// BCD word for the display from the last / best / history views.
module score_history_unit #(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] TIMEOUT_CODE = score_history_unit_pkg::TIMEOUT_CODE
) (
    input logic                  Clk,
    input logic                  Reset,
    score_history_unit_if.slave  bus
);
    import score_history_unit_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [15:0]   last_q, best_q, score_q;
    logic          best_valid_q, bad_q;
    view_t         view_q, nxt_view;
    logic [IW-1:0] idx_q, nxt_idx;

    logic          capture, accept_valid, discard, take_best;
    logic [15:0]   cap_data, nxt_last, nxt_best, nxt_score, rd_data;
    logic          nxt_best_valid;
    logic [CW-1:0] cnt;

    score_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (capture),
        .wr_data (cap_data),
        .rd_idx  (nxt_idx),
        .rd_data (rd_data),
        .cnt     (cnt)
    );

    always_comb begin
        accept_valid   = bus.Update && !bus.Timeout && bcd_word_ok(bus.ScoreIn);
        discard        = bus.Update && !bus.Timeout && !bcd_word_ok(bus.ScoreIn);
        capture        = accept_valid || (bus.Update && bus.Timeout);
        cap_data       = bus.Timeout ? TIMEOUT_CODE : bus.ScoreIn;
        take_best      = accept_valid && (!best_valid_q || bus.ScoreIn < best_q);
        nxt_last       = capture ? cap_data : last_q;
        nxt_best       = take_best ? bus.ScoreIn : best_q;
        nxt_best_valid = best_valid_q || take_best;
    end

    // View transitions; an update (even a discarded one) outranks ShowPrev.
    always_comb begin
        nxt_view = view_q;
        nxt_idx  = idx_q;
        if (bus.ShowBest) begin
            nxt_view = VIEW_BEST;
            nxt_idx  = '0;
        end else if (bus.Update || view_q == VIEW_BEST) begin
            nxt_view = VIEW_LAST;
            nxt_idx  = '0;
        end else if (bus.ShowPrev) begin
            if (view_q == VIEW_LAST && cnt >= CW'(2)) begin
                nxt_view = VIEW_HIST;
                nxt_idx  = IW'(1);
            end else if (view_q == VIEW_HIST) begin
                if (CW'(idx_q) + CW'(1) == cnt) begin
                    nxt_view = VIEW_LAST;
                    nxt_idx  = '0;
                end else begin
                    nxt_idx = idx_q + 1'b1;
                end
            end
        end
    end

    // HIST is only entered without a same-cycle write, so rd_data is current.
    always_comb begin
        nxt_score = nxt_last;
        case (nxt_view)
            VIEW_BEST: nxt_score = nxt_best_valid ? nxt_best : 16'h0000;
            VIEW_HIST: nxt_score = rd_data;
            default:   nxt_score = nxt_last;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q       <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            bad_q        <= 1'b0;
            view_q       <= VIEW_LAST;
            idx_q        <= '0;
            score_q      <= '0;
        end else begin
            last_q       <= nxt_last;
            best_q       <= nxt_best;
            best_valid_q <= nxt_best_valid;
            if (discard) bad_q <= 1'b1;
            view_q       <= nxt_view;
            idx_q        <= nxt_idx;
            score_q      <= nxt_score;
        end
    end

    assign bus.ScoreOut  = score_q;
    assign bus.BestValid = best_valid_q;
    assign bus.HistIdx   = idx_q;
    assign bus.BadBcd    = bad_q;

endmodule

// File: doc/score_history_unit.md
# score_history_unit

Result-keeping stage of the reaction-timer game. It sits downstream of the millisecond BCD counter and control FSM, and upstream of the 4-digit seven-segment controller. On each score-update pulse it captures the 4-digit BCD reaction time, tracks the best (lowest) valid score, and keeps a ring buffer of recent scores. It drives the 16-bit BCD word shown on the display according to the user's view buttons.

## Interface
- `DEPTH`, 4: history entries, power of two, 2..16
- `TIMEOUT_CODE`, 16'h9999: BCD value recorded for a timed-out round
- `Clk`  in  1  system clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-high; clears all state immediately
- `Update`  in  1  one-cycle pulse from control FSM: capture `ScoreIn`
- `Timeout`  in  1  qualifies `Update`: round ended on counter rollover, no valid score
- `ScoreIn`  in  16  BCD reaction time, digits [15:12]..[3:0], ms
- `ShowBest`  in  1  synchronized level: while high, display best score
- `ShowPrev`  in  1  synchronized one-cycle pulse: step one entry back in history
- `ScoreOut`  out  16  BCD word to the segment controller
- `BestValid`  out  1  at least one valid score since reset
- `HistIdx`  out  $clog2(DEPTH)  history entry displayed (0 = newest)
- `BadBcd`  out  1  sticky: an `Update` carried a digit > 9

## Operation
- Registers: `last`, `best`, `hist[DEPTH]`, write pointer `wp`, fill count `cnt` (0..DEPTH), view state, `HistIdx`, `BadBcd`.
- Valid update: `Update`=1, `Timeout`=0, all four digits ≤ 9.
  - `last`←`ScoreIn`; `hist[wp]`←`ScoreIn`; `wp`←`wp`+1 mod DEPTH; `cnt` saturates at DEPTH.
  - If `!BestValid` or `ScoreIn` < `best`, then `best`←`ScoreIn`, `BestValid`←1.
  - BCD compare is a plain 16-bit unsigned compare. This is exact for valid BCD.
  - An equal score leaves `best` unchanged.
- Timeout update: `last` and `hist` get `TIMEOUT_CODE`; pointer and count advance; `best` and `BestValid` are untouched.
- Invalid BCD with `Timeout`=0: the update is discarded entirely and `BadBcd`←1. `BadBcd` clears only on `Reset`.
- View FSM, three states:
  - LAST: `ScoreOut`=`last`.
  - BEST: `ScoreOut`=`best`, or 16'h0000 if `!BestValid`.
  - HIST: `ScoreOut`=`hist[(wp-1-HistIdx) mod DEPTH]`.
- Transitions, in priority order:
  1. `ShowBest`=1 → BEST from any state. Leaving BEST returns to LAST with `HistIdx`=0.
  2. Any `Update` (accepted or discarded) → LAST with `HistIdx`=0.
  3. `ShowPrev` in LAST → HIST with `HistIdx`=1, if `cnt` ≥ 2; else no change.
  4. `ShowPrev` in HIST → `HistIdx`+1. If that would reach `cnt`, go to LAST with `HistIdx`=0 (wrap).
  - `ShowPrev` is ignored while in BEST.

## Timing
- Reset values:
  - `ScoreOut`=16'h0000, `BestValid`=0, `HistIdx`=0, `BadBcd`=0, state LAST.
  - `last`, `best`, and all `hist` entries = 0; `wp`=0, `cnt`=0.
- `ScoreOut` is registered. The new `last` appears on the first rising edge after the `Update` cycle, i.e. 1-cycle latency.
- A view change is also 1-cycle latency.
- Same edge `Update` + `ShowPrev`: the update wins and `ShowPrev` is dropped.
- Same edge `Update` + `ShowBest`: the capture happens. `ScoreOut` then shows the new best in the following cycle, since the best update and the view select read registered `best` one cycle apart at most.
- `Update` pulses on consecutive cycles are each accepted.
- `Reset` asserted mid-operation clears everything asynchronously. No partial capture survives.
- Pointer wrap: after DEPTH+1 valid updates, the oldest entry is overwritten and `cnt` stays DEPTH.

## Structure
- Shared package/include: `TIMEOUT_CODE`, view-state encodings (LAST/BEST/HIST), and a BCD-digit-valid function reused by the millisecond counter.
- One natural sub-module: `score_ring_buffer`, which holds the `hist` storage, `wp`, `cnt`, and indexed read. The top holds `best`/`last` and the view FSM.

## Test plan
- Reset, then `Update` with `ScoreIn`=16'h0250 → next cycle `ScoreOut`=0250 and `BestValid`=1. Hold `ShowBest` → 0250.
- Scores 0310, 0190, 0190, 0400 → `best`=0190. Press `ShowPrev` 3 times: shows 0190 (Idx1), 0190 (Idx2), 0310 (Idx3). Fourth press → LAST, shows 0400.
- `Update`+`Timeout` as the first event → `ScoreOut`=9999, `BestValid`=0, `ShowBest` shows 0000. A following valid 0500 makes `best`=0500.
- `ScoreIn`=16'h01A3 → update dropped, `BadBcd`=1, `ScoreOut` unchanged, `cnt` unchanged.
- DEPTH=4: six valid updates 0101..0106 → history view from newest reads 0106, 0105, 0104, 0103, then wraps to LAST.
- `Reset` pulsed while in HIST with `BestValid`=1 → immediately `ScoreOut`=0000, `BestValid`=0, `HistIdx`=0, and the next `ShowPrev` is ignored.
